// File: rtl/palette_ram_ctrl.sv
// palette_ram_ctrl
// Owns the 64 x 15-bit custom palette RAM. Pixel reads and palette downloads
// share its single port. Download bytes are paired into little-endian 16-bit
// entries, and bit 15 of each entry is dropped. A paired entry is parked in a
// one-deep pending register, then written on the first cycle with no pixel
// read. pal_loaded reports whether the last session delivered exactly 64
// well-ordered entries.
module palette_ram_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_active,
  input  logic        dl_valid,
  output logic        dl_ready,
  input  logic [6:0]  dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        rd_ce,
  input  logic [5:0]  rd_index,
  output logic [14:0] rd_data,
  output logic        rd_valid,
  output logic        pal_loaded,
  output logic [6:0]  wr_count,
  output logic        err_order
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_r;
  logic        armed_r;
  logic        lo_valid_r;
  logic [7:0]  lo_byte_r;
  logic [5:0]  lo_idx_r;
  logic        pend_r;
  logic [5:0]  pend_idx_r;
  logic [14:0] pend_data_r;
  logic        dl_ready_r;
  logic        pal_loaded_r;
  logic [6:0]  wr_count_r;
  logic        err_order_r;
  logic [14:0] rd_data_r;
  logic        rd_valid_r;

  logic [14:0] ram_r [0:63];

  logic accept_s;
  logic even_s;
  logic pair_ok_s;
  logic wr_en_s;
  logic pend_nxt_s;
  logic go_load_s;
  logic stay_load_s;
  logic dl_data_unused_s;

  // Bit 7 of a high byte would be entry bit 15; the RAM is only 15 bits wide.
  assign dl_data_unused_s = dl_data[7];

  // Saturating entry counter increment.
  function automatic logic [6:0] sat_inc7(input logic [6:0] v);
    if (v == 7'd127) begin
      return 7'd127;
    end else begin
      return v + 7'd1;
    end
  endfunction

  // Decode this cycle's download handshake and single-port arbitration.
  always_comb begin
    accept_s    = (state_r == LOAD) && dl_valid && dl_ready_r;
    even_s      = ~dl_addr[0];
    pair_ok_s   = accept_s && dl_addr[0] && lo_valid_r && (lo_idx_r == dl_addr[6:1]);
    wr_en_s     = pend_r && ~rd_ce;
    go_load_s   = (state_r == IDLE) && load_active && armed_r;
    stay_load_s = (state_r == LOAD) && load_active;
    if (pair_ok_s) begin
      pend_nxt_s = 1'b1;
    end else if (wr_en_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Session FSM: byte pairing, pending write, counters and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      armed_r      <= 1'b0;
      lo_valid_r   <= 1'b0;
      lo_byte_r    <= 8'd0;
      lo_idx_r     <= 6'd0;
      pend_r       <= 1'b0;
      pend_idx_r   <= 6'd0;
      pend_data_r  <= 15'd0;
      dl_ready_r   <= 1'b0;
      pal_loaded_r <= 1'b0;
      wr_count_r   <= 7'd0;
      err_order_r  <= 1'b0;
    end else begin
      // Ready is offered only while in LOAD next cycle with nothing parked.
      dl_ready_r <= (go_load_s || stay_load_s) && ~pend_nxt_s;
      pend_r     <= pend_nxt_s;
      if (pair_ok_s) begin
        pend_data_r <= {dl_data[6:0], lo_byte_r};
        pend_idx_r  <= lo_idx_r;
      end
      case (state_r)
        IDLE: begin
          if (go_load_s) begin
            state_r      <= LOAD;
            wr_count_r   <= 7'd0;
            err_order_r  <= 1'b0;
            pal_loaded_r <= 1'b0;
            lo_valid_r   <= 1'b0;
            armed_r      <= 1'b0;
          end else if (~load_active) begin
            // A load level held through reset must drop before a session starts.
            armed_r <= 1'b1;
          end
        end
        LOAD: begin
          if (wr_en_s) begin
            wr_count_r <= sat_inc7(wr_count_r);
          end
          if (accept_s && even_s) begin
            lo_byte_r  <= dl_data;
            lo_idx_r   <= dl_addr[6:1];
            lo_valid_r <= 1'b1;
            if (lo_valid_r) begin
              err_order_r <= 1'b1;
            end
          end else if (pair_ok_s) begin
            lo_valid_r <= 1'b0;
          end else if (accept_s) begin
            // High byte without a matching low byte is dropped.
            err_order_r <= 1'b1;
          end
          if (~load_active) begin
            state_r    <= FINISH;
            lo_valid_r <= 1'b0;
            if ((lo_valid_r && ~pair_ok_s) || (accept_s && even_s)) begin
              err_order_r <= 1'b1;
            end
          end
        end
        FINISH: begin
          if (wr_en_s) begin
            wr_count_r <= sat_inc7(wr_count_r);
          end
          if (~pend_r) begin
            pal_loaded_r <= (wr_count_r == 7'd64) && ~err_order_r;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Pixel read port: one-cycle latency, rd_valid pulses with each result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r  <= 15'd0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_ce;
      if (rd_ce) begin
        rd_data_r <= ram_r[rd_index];
      end
    end
  end

  // Palette storage: retained across reset and session start.
  always_ff @(posedge clk) begin
    if (wr_en_s && ~reset) begin
      ram_r[pend_idx_r] <= pend_data_r;
    end
  end

  assign dl_ready   = dl_ready_r;
  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;
  assign pal_loaded = pal_loaded_r;
  assign wr_count   = wr_count_r;
  assign err_order  = err_order_r;

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Testbench for palette_ram_ctrl. It runs directed download sessions with
// randomized entry data and random pixel reads. A behavioural model of the
// palette contents and session status supplies every expected value.
`timescale 1ns/1ps
module tb_palette_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_active;
  logic        dl_valid;
  logic        dl_ready;
  logic [6:0]  dl_addr;
  logic [7:0]  dl_data;
  logic        rd_ce;
  logic [5:0]  rd_index;
  logic [14:0] rd_data;
  logic        rd_valid;
  logic        pal_loaded;
  logic [6:0]  wr_count;
  logic        err_order;

  always #5 clk = ~clk;

  palette_ram_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .load_active (load_active),
    .dl_valid    (dl_valid),
    .dl_ready    (dl_ready),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .rd_ce       (rd_ce),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .pal_loaded  (pal_loaded),
    .wr_count    (wr_count),
    .err_order   (err_order)
  );

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int last_rd = -100;
  int inflight_idx = -1;
  int inflight_cyc = -100;
  bit last_did_rd = 1'b0;

  // Reference model: palette contents plus session bookkeeping.
  logic [14:0] model_ram [0:63];
  bit          model_known [0:63];
  int          m_count;
  bit          m_err;
  bit          m_lov;
  logic [5:0]  m_loi;
  logic [7:0]  m_lob;
  logic [15:0] ent [0:63];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. It may issue a pixel read (at least 4 cycles apart)
  // and checks any read issued.
  task automatic tick(input bit allow_rd, input bit force_rd, input int force_idx);
    bit          do_rd;
    bit          known;
    int          idx;
    logic [14:0] exp;
    do_rd = 1'b0;
    known = 1'b0;
    idx   = 0;
    exp   = 15'd0;
    if (cyc - last_rd >= 4) begin
      if (force_rd || force_idx >= 0) do_rd = 1'b1;
      else if (allow_rd && $urandom_range(0, 3) == 0) do_rd = 1'b1;
    end
    if (do_rd) begin
      idx = (force_idx >= 0) ? force_idx : int'($urandom_range(0, 63));
      if (idx == inflight_idx && cyc - inflight_cyc < 4) idx = idx ^ 1;
      known    = model_known[idx];
      exp      = model_ram[idx];
      last_rd  = cyc;
      rd_ce    = 1'b1;
      rd_index = 6'(idx);
    end else begin
      rd_ce = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    rd_ce = 1'b0;
    last_did_rd = do_rd;
    if (do_rd) begin
      check("rd_valid", 16'(rd_valid), 16'd1);
      if (known) check("rd_data", 16'(rd_data), 16'(exp));
    end
  endtask

  task automatic model_byte(input logic [6:0] a, input logic [7:0] d, output bit paired);
    paired = 1'b0;
    if (a[0] == 1'b0) begin
      if (m_lov) m_err = 1'b1;
      m_lov = 1'b1;
      m_lob = d;
      m_loi = a[6:1];
    end else if (m_lov && m_loi == a[6:1]) begin
      model_ram[a[6:1]]   = {d[6:0], m_lob};
      model_known[a[6:1]] = 1'b1;
      if (m_count < 127) m_count++;
      m_lov  = 1'b0;
      paired = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [6:0] a, input logic [7:0] d, input bit allow_rd, input bit collide);
    int n;
    bit paired;
    dl_valid = 1'b1;
    dl_addr  = a;
    dl_data  = d;
    n = 0;
    while (dl_ready !== 1'b1 && n < 16) begin
      tick(allow_rd, 1'b0, -1);
      n++;
    end
    check("dl_ready_wait", 16'(dl_ready), 16'd1);
    tick(allow_rd, 1'b0, -1);
    dl_valid = 1'b0;
    model_byte(a, d, paired);
    if (paired) begin
      inflight_idx = int'(a[6:1]);
      inflight_cyc = cyc;
      if (collide) begin
        tick(1'b0, 1'b1, -1);
        if (last_did_rd) check("wr_deferred_ready", 16'(dl_ready), 16'd0);
      end else begin
        check("pend_ready_low", 16'(dl_ready), 16'd0);
      end
    end
  endtask

  task automatic begin_session(input bit allow_rd);
    load_active = 1'b0;
    tick(allow_rd, 1'b0, -1);
    tick(allow_rd, 1'b0, -1);
    load_active = 1'b1;
    tick(allow_rd, 1'b0, -1);
    m_count = 0;
    m_err   = 1'b0;
    m_lov   = 1'b0;
    check("start_wr_count", 16'(wr_count), 16'd0);
    check("start_pal_loaded", 16'(pal_loaded), 16'd0);
    check("start_dl_ready", 16'(dl_ready), 16'd1);
  endtask

  task automatic end_session();
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    load_active = 1'b0;
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    if (m_lov) m_err = 1'b1;
    check("pal_loaded", 16'(pal_loaded), 16'(m_count == 64 && !m_err));
    check("wr_count", 16'(wr_count), 16'(m_count));
    check("err_order", 16'(err_order), 16'(m_err));
  endtask

  task automatic read_expect(input int idx, input logic [14:0] exp);
    while (cyc - last_rd < 4) tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, idx);
    check("rd_directed", 16'(rd_data), 16'(exp));
  endtask

  task automatic send_entries(input int nbytes, input bit allow_rd, input bit collide);
    logic [15:0] v;
    for (int b = 0; b < nbytes; b++) begin
      v = ent[b / 2];
      send_byte(7'(b), (b % 2 == 1) ? v[15:8] : v[7:0], allow_rd, collide);
    end
  endtask

  task automatic random_entries();
    for (int i = 0; i < 64; i++) ent[i] = 16'($urandom);
  endtask

  initial begin
    reset       = 1'b1;
    load_active = 1'b0;
    dl_valid    = 1'b0;
    dl_addr     = 7'd0;
    dl_data     = 8'd0;
    rd_ce       = 1'b0;
    rd_index    = 6'd0;
    m_count     = 0;
    m_err       = 1'b0;
    m_lov       = 1'b0;
    m_loi       = 6'd0;
    m_lob       = 8'd0;
    for (int i = 0; i < 64; i++) begin
      model_known[i] = 1'b0;
      model_ram[i]   = 15'd0;
    end
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    check("rst_dl_ready", 16'(dl_ready), 16'd0);
    check("rst_rd_data", 16'(rd_data), 16'd0);
    check("rst_rd_valid", 16'(rd_valid), 16'd0);
    check("rst_pal_loaded", 16'(pal_loaded), 16'd0);
    check("rst_wr_count", 16'(wr_count), 16'd0);
    check("rst_err_order", 16'(err_order), 16'd0);
    reset = 1'b0;
    tick(1'b0, 1'b0, -1);

    // Full in-order load, entry i = 0x0100 + i, with random pixel reads.
    for (int i = 0; i < 64; i++) ent[i] = 16'h0100 + 16'(i);
    begin_session(1'b1);
    send_entries(128, 1'b1, 1'b0);
    end_session();
    read_expect(5, 15'h0105);

    // Every write collides with a pixel read issued in its pending cycle.
    random_entries();
    begin_session(1'b0);
    send_entries(128, 1'b0, 1'b1);
    end_session();
    for (int i = 0; i < 60; i++) tick(1'b1, 1'b0, -1);

    // Short load: 63 entries only.
    random_entries();
    begin_session(1'b1);
    send_entries(126, 1'b1, 1'b0);
    end_session();

    // Order error: byte 3 before byte 2.
    random_entries();
    begin_session(1'b1);
    send_byte(7'd0, ent[0][7:0], 1'b1, 1'b0);
    send_byte(7'd1, ent[0][15:8], 1'b1, 1'b0);
    send_byte(7'd3, ent[1][15:8], 1'b1, 1'b0);
    check("order_err_flag", 16'(err_order), 16'd1);
    for (int b = 2; b < 128; b++)
      send_byte(7'(b), (b % 2 == 1) ? ent[b / 2][15:8] : ent[b / 2][7:0], 1'b1, 1'b0);
    end_session();

    // High byte bit 7 is dropped.
    begin_session(1'b1);
    send_byte(7'd0, 8'h34, 1'b1, 1'b0);
    send_byte(7'd1, 8'hFF, 1'b1, 1'b0);
    end_session();
    read_expect(0, 15'h7F34);

    // Reset after 40 bytes with load_active still high.
    random_entries();
    begin_session(1'b1);
    send_entries(40, 1'b1, 1'b0);
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    tick(1'b0, 1'b0, -1);
    reset = 1'b1;
    tick(1'b0, 1'b0, -1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, -1);
    check("rst_mid_dl_ready", 16'(dl_ready), 16'd0);
    check("rst_mid_wr_count", 16'(wr_count), 16'd0);
    check("rst_mid_pal_loaded", 16'(pal_loaded), 16'd0);
    check("rst_mid_rd_data", 16'(rd_data), 16'd0);
    random_entries();
    begin_session(1'b1);
    send_entries(128, 1'b1, 1'b0);
    end_session();
    for (int i = 0; i < 60; i++) tick(1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
